plab2_proc_pic_multi: RTL

Parametrised programmable interrupt controller for the multicore processor. It arbitrates level interrupt requests from `p_num_src` sources using per-source programmable priorities, in either fixed or round-robin tie-break mode. It returns a one-hot acknowledge, then a one-hot delivery (`intr_val`) held until the target accepts it. It sits between the cores/peripherals and the per-core interrupt inputs, and generalises the two-source, one-bit-priority controller.

---
 rtl/plab2_proc_pic_pkg.sv | 17 +
 rtl/plab2_proc_pic_arbiter.sv | 66 ++++++
 rtl/plab2_proc_pic_multi.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/plab2_proc_pic_pkg.sv
// Shared definitions for the multi-source programmable interrupt controller.
//   state_e        : controller FSM encoding (2 bits)
//   PIC_MODE_FIXED : tie-break towards the lowest requesting index
//   PIC_MODE_RR    : tie-break starting at the round-robin pointer
package plab2_proc_pic_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_ACK  = 2'd1,
    STATE_RESP = 2'd2,
    STATE_HOLD = 2'd3
  } state_e;

  localparam logic PIC_MODE_FIXED = 1'b0;
  localparam logic PIC_MODE_RR    = 1'b1;

endpackage

// File: rtl/plab2_proc_pic_arbiter.sv
// Combinational winner selection for the interrupt controller.
//   req_i     : request vector, bit i from source i
//   prio_i    : flattened priorities, field i = [i*p_prio_bits +: p_prio_bits]
//   rr_ptr_i  : first index considered on a tie in round-robin mode
//   mode_i    : PIC_MODE_FIXED or PIC_MODE_RR
//   winner_o  : index of the selected source (0 when nothing requests)
//   any_req_o : at least one request bit is set
module plab2_proc_pic_arbiter
  import plab2_proc_pic_pkg::*;
#(
  parameter int p_num_src   = 4,
  parameter int p_prio_bits = 2,
  localparam int IW         = $clog2(p_num_src)
) (
  input  logic [p_num_src-1:0]             req_i,
  input  logic [p_num_src*p_prio_bits-1:0] prio_i,
  input  logic [IW-1:0]                    rr_ptr_i,
  input  logic                             mode_i,
  output logic [IW-1:0]                    winner_o,
  output logic                             any_req_o
);

  logic [p_prio_bits-1:0] max_prio_s;
  logic                   found_s;
  int                     base_s;
  int                     idx_s;

  // Two passes: find the highest requesting priority, then scan for the
  // first requester holding it, starting at 0 (fixed) or rr_ptr (round-robin).
  always_comb begin
    max_prio_s = '0;
    any_req_o  = 1'b0;
    winner_o   = '0;
    found_s    = 1'b0;
    idx_s      = 0;
    if (mode_i == PIC_MODE_RR) begin
      base_s = int'(rr_ptr_i);
    end else begin
      base_s = 0;
    end
    for (int i = 0; i < p_num_src; i++) begin
      if (req_i[i] && (!any_req_o || (prio_i[i*p_prio_bits +: p_prio_bits] > max_prio_s))) begin
        max_prio_s = prio_i[i*p_prio_bits +: p_prio_bits];
        any_req_o  = 1'b1;
      end else begin
        max_prio_s = max_prio_s;
      end
    end
    for (int k = 0; k < p_num_src; k++) begin
      // Wrap without a modulo so non-power-of-two source counts work.
      idx_s = base_s + k;
      if (idx_s >= p_num_src) begin
        idx_s = idx_s - p_num_src;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_i[idx_s] && (prio_i[idx_s*p_prio_bits +: p_prio_bits] == max_prio_s)) begin
        found_s  = 1'b1;
        winner_o = IW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

endmodule

// File: rtl/plab2_proc_pic_multi.sv
// Multi-source programmable interrupt controller (IDLE -> ACK -> RESP -> HOLD).
//   clk_i          : clock
//   reset_i        : synchronous active-high reset
//   intr_rq_i      : level requests, held until acknowledged
//   prio_wr_en_i   : per-source priority write enables
//   prio_wr_data_i : flattened priority write data
//   mode_i         : tie-break mode, sampled only in IDLE
//   intr_rdy_i     : per-target delivery accept
//   intr_ack_o     : one-hot acknowledge (ACK state)
//   intr_val_o     : one-hot delivery (RESP state)
//   intr_id_o      : index of current grant, 0 when none
//   busy_o         : controller not in IDLE
module plab2_proc_pic_multi
  import plab2_proc_pic_pkg::*;
#(
  parameter int p_num_src   = 4,
  parameter int p_prio_bits = 2,
  parameter int p_holdoff   = 15,
  localparam int IW         = $clog2(p_num_src)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [p_num_src-1:0]             intr_rq_i,
  input  logic [p_num_src-1:0]             prio_wr_en_i,
  input  logic [p_num_src*p_prio_bits-1:0] prio_wr_data_i,
  input  logic                             mode_i,
  input  logic [p_num_src-1:0]             intr_rdy_i,
  output logic [p_num_src-1:0]             intr_ack_o,
  output logic [p_num_src-1:0]             intr_val_o,
  output logic [IW-1:0]                    intr_id_o,
  output logic                             busy_o
);

  // Counter needs at least one bit even when HOLD is skipped.
  localparam int CW = (p_holdoff > 0) ? $clog2(p_holdoff + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (p_holdoff > 0) ? CW'(p_holdoff - 1) : '0;
  localparam logic [p_num_src-1:0] ONE_N = {{(p_num_src-1){1'b0}}, 1'b1};

  state_e                           state_q, state_d;
  logic [IW-1:0]                    grant_q, grant_d;
  logic [IW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [p_num_src*p_prio_bits-1:0] prio_q, prio_d;
  logic [p_num_src-1:0]             ack_q, ack_d;
  logic [p_num_src-1:0]             val_q, val_d;
  logic [IW-1:0]                    id_q, id_d;
  logic                             busy_q, busy_d;
  logic [IW-1:0]                    winner_s;
  logic                             any_req_s;

  // The arbiter sees the registered priorities, so a write in the sampling
  // cycle only affects the following selection.
  plab2_proc_pic_arbiter #(
    .p_num_src   (p_num_src),
    .p_prio_bits (p_prio_bits)
  ) u_arbiter (
    .req_i     (intr_rq_i),
    .prio_i    (prio_q),
    .rr_ptr_i  (rr_ptr_q),
    .mode_i    (mode_i),
    .winner_o  (winner_s),
    .any_req_o (any_req_s)
  );

  // Per-source priority register update.
  always_comb begin
    prio_d = prio_q;
    for (int i = 0; i < p_num_src; i++) begin
      if (prio_wr_en_i[i]) begin
        prio_d[i*p_prio_bits +: p_prio_bits] = prio_wr_data_i[i*p_prio_bits +: p_prio_bits];
      end else begin
        prio_d[i*p_prio_bits +: p_prio_bits] = prio_q[i*p_prio_bits +: p_prio_bits];
      end
    end
  end

  // FSM next state, grant latch, round-robin pointer and holdoff counter.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (any_req_s) begin
          grant_d = winner_s;
          state_d = STATE_ACK;
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_ACK: begin
        state_d = STATE_RESP;
      end
      STATE_RESP: begin
        if (intr_rdy_i[grant_q]) begin
          if (grant_q == IW'(p_num_src - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_q + IW'(1);
          end
          if (p_holdoff == 0) begin
            state_d = STATE_IDLE;
          end else begin
            state_d = STATE_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          state_d = STATE_RESP;
        end
      end
      STATE_HOLD: begin
        if (cnt_q == '0) begin
          state_d = STATE_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ack_d  = '0;
    val_d  = '0;
    id_d   = '0;
    busy_d = (state_d != STATE_IDLE);
    case (state_d)
      STATE_ACK: begin
        ack_d = ONE_N << grant_d;
        id_d  = grant_d;
      end
      STATE_RESP: begin
        val_d = ONE_N << grant_d;
        id_d  = grant_d;
      end
      default: begin
        id_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= STATE_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      prio_q   <= '0;
      ack_q    <= '0;
      val_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      ack_q    <= ack_d;
      val_q    <= val_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
    end
  end

  assign intr_ack_o = ack_q;
  assign intr_val_o = val_q;
  assign intr_id_o  = id_q;
  assign busy_o     = busy_q;

endmodule
